// File: rtl/filter_sweep_ctrl.sv
// filter_sweep_ctrl
//   Steps a sine generator through a range of periods. For each step it
//   loads the period, optionally lets the filters settle, streams a run of
//   capture samples, then holds the generator off for a fixed gap.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   start, abort         sweep control (abort wins; start only in IDLE)
//   period_start/step/stop  sweep bounds, latched on accepted start
//   osc_count            oscillations per step, latched on accepted start
//   settle_cycles        discard window per step (settle build only)
//   capture_ready        downstream logger can accept a sample
//   period_out           period driven to the sine generator
//   gen_en               releases generator and filters
//   capture_valid        current sample is to be logged
//   step_index           zero-based step number
//   busy/done/overrun/cfg_err  status flags
//
// Build option
//   FILTER_SWEEP_SETTLE_EN : adds a SETTLE state of settle_cycles cycles
//                            between LOAD and RUN.
module filter_sweep_ctrl #(
    parameter int unsigned PERIOD_W   = 32,
    parameter int unsigned CNT_W      = 40,
    parameter int unsigned GAP_CYCLES = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period_start,
    input  logic [PERIOD_W-1:0] period_step,
    input  logic [PERIOD_W-1:0] period_stop,
    input  logic [15:0]         osc_count,
    input  logic [15:0]         settle_cycles,
    input  logic                capture_ready,
    output logic [PERIOD_W-1:0] period_out,
    output logic                gen_en,
    output logic                capture_valid,
    output logic [15:0]         step_index,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                cfg_err
);

    // period * osc_count * 1024 needs PERIOD_W + 16 + 10 bits before saturation
    localparam int unsigned PW = PERIOD_W + 26;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_GAP, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] period_q, step_q, stop_q;
    logic [15:0]         osc_q;
    logic [CNT_W-1:0]    run_len, cnt, cnt_inc, run_len_calc;
    logic [PW-1:0]       prod;
    logic [PERIOD_W:0]   next_sum;
    logic                sweep_end;

`ifdef FILTER_SWEEP_SETTLE_EN
    logic [15:0] settle_q;
`else
    logic settle_unused;
    assign settle_unused = ^settle_cycles;
`endif

    assign cnt_inc   = cnt + CNT_W'(1);
    assign next_sum  = {1'b0, period_q} + {1'b0, step_q};
    assign sweep_end = (step_q == '0) || next_sum[PERIOD_W] ||
                       (next_sum[PERIOD_W-1:0] > stop_q);

    always_comb begin
        prod = (PW'(period_q) * PW'(osc_q)) << 10;
        if (|prod[PW-1:CNT_W])
            run_len_calc = '1;
        else
            run_len_calc = prod[CNT_W-1:0];
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_LOAD;
            S_LOAD: begin
                if (cfg_err)
                    state_nxt = S_DONE;
                else begin
`ifdef FILTER_SWEEP_SETTLE_EN
                    state_nxt = (settle_q != '0) ? S_SETTLE : S_RUN;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_SETTLE: begin
`ifdef FILTER_SWEEP_SETTLE_EN
                if (cnt_inc == CNT_W'(settle_q)) state_nxt = S_RUN;
`else
                state_nxt = S_RUN;
`endif
            end
            S_RUN:    if (cnt_inc == run_len) state_nxt = S_GAP;
            S_GAP:    if (cnt_inc == CNT_W'(GAP_CYCLES))
                          state_nxt = sweep_end ? S_DONE : S_LOAD;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // abort overrides every transition out of a non-idle state
        if (abort && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    // outputs
    always_comb begin
        gen_en        = (state == S_SETTLE) || (state == S_RUN);
        capture_valid = (state == S_RUN);
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
    end

    // datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q   <= '0;
            step_q     <= '0;
            stop_q     <= '0;
            osc_q      <= '0;
            run_len    <= '0;
            cnt        <= '0;
            period_out <= '0;
            step_index <= '0;
            overrun    <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef FILTER_SWEEP_SETTLE_EN
            settle_q   <= '0;
`endif
        end else begin
            // cycle counter restarts on every state change
            if (state_nxt == state &&
                (state == S_SETTLE || state == S_RUN || state == S_GAP))
                cnt <= cnt_inc;
            else
                cnt <= '0;

            case (state)
                S_IDLE: if (state_nxt == S_LOAD) begin
                    period_q   <= (period_start == '0) ? PERIOD_W'(1) : period_start;
                    step_q     <= period_step;
                    stop_q     <= period_stop;
                    osc_q      <= (osc_count == '0) ? 16'd1 : osc_count;
`ifdef FILTER_SWEEP_SETTLE_EN
                    settle_q   <= settle_cycles;
`endif
                    step_index <= '0;
                    overrun    <= 1'b0;
                    cfg_err    <= (period_start > period_stop);
                end
                S_LOAD: begin
                    period_out <= period_q;
                    run_len    <= run_len_calc;
                end
                S_RUN: if (!capture_ready) overrun <= 1'b1;
                S_GAP: if (state_nxt == S_LOAD) begin
                    period_q   <= next_sum[PERIOD_W-1:0];
                    step_index <= step_index + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
module tb_filter_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, capture_ready;
    logic [31:0] period_start, period_step, period_stop, period_out;
    logic [15:0] osc_count, settle_cycles, step_index;
    logic        gen_en, capture_valid, busy, done, overrun, cfg_err;

    int checks   = 0;
    int failures = 0;

    // burst/gap record for one observed sweep
    int          nb, dones, cv_total;
    bit          gen_seen, timed_out;
    int          burst_len [8];
    int          gap_len   [8];
    logic [63:0] burst_per [8];
    logic [63:0] burst_idx [8];

    filter_sweep_ctrl #(
        .PERIOD_W  (32),
        .CNT_W     (40),
        .GAP_CYCLES(100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .period_start (period_start),
        .period_step  (period_step),
        .period_stop  (period_stop),
        .osc_count    (osc_count),
        .settle_cycles(settle_cycles),
        .capture_ready(capture_ready),
        .period_out   (period_out),
        .gen_en       (gen_en),
        .capture_valid(capture_valid),
        .step_index   (step_index),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .cfg_err      (cfg_err)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [31:0] ps, input logic [31:0] st,
                        input logic [31:0] sp, input logic [15:0] osc);
        @(negedge clk);
        period_start  = ps;
        period_step   = st;
        period_stop   = sp;
        osc_count     = osc;
        settle_cycles = 16'd50;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Watch one sweep until busy drops. abort_at / drop_at count capture
    // cycles (0 = unused): abort is raised, or capture_ready dropped for one
    // cycle, right after that many capture cycles have been seen.
    task automatic observe(input int budget, input int abort_at, input int drop_at);
        int cur, low_run;
        nb = 0; dones = 0; cv_total = 0; gen_seen = 0; timed_out = 1;
        cur = 0; low_run = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            capture_ready = 1'b1;
            abort         = 1'b0;
            if (done)   dones++;
            if (gen_en) gen_seen = 1;
            if (capture_valid) begin
                if (cur == 0 && nb < 8) begin
                    burst_per[nb] = 64'(period_out);
                    burst_idx[nb] = 64'(step_index);
                    gap_len[nb]   = low_run;
                end
                cur++;
                cv_total++;
                if (abort_at != 0 && cv_total == abort_at) abort = 1'b1;
                if (drop_at  != 0 && cv_total == drop_at)  capture_ready = 1'b0;
            end else begin
                if (cur != 0) begin
                    if (nb < 8) burst_len[nb] = cur;
                    nb++;
                    cur     = 0;
                    low_run = 0;
                end
                low_run++;
            end
            if (!busy) begin
                timed_out = 0;
                break;
            end
        end
        check("sweep_timeout", 64'(timed_out), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; capture_ready = 1'b1;
        period_start = '0; period_step = '0; period_stop = '0;
        osc_count = '0; settle_cycles = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_period_out", 64'(period_out), 64'd0);
        check("rst_gen_en", 64'(gen_en), 64'd0);
        check("rst_capture_valid", 64'(capture_valid), 64'd0);
        check("rst_step_index", 64'(step_index), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;

        // start together with abort in IDLE is ignored
        @(negedge clk);
        period_start = 32'd10; period_step = 32'd5; period_stop = 32'd20; osc_count = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_ignored", 64'(busy), 64'd0);

        // 10/5/20 sweep: three bursts, gaps of GAP(100) + LOAD(1) idle capture cycles
        kick(32'd10, 32'd5, 32'd20, 16'd1);
        observe(60000, 0, 0);
        check("sw1_bursts", 64'(nb), 64'd3);
        check("sw1_len0", 64'(burst_len[0]), 64'd10240);
        check("sw1_len1", 64'(burst_len[1]), 64'd15360);
        check("sw1_len2", 64'(burst_len[2]), 64'd20480);
        check("sw1_per0", burst_per[0], 64'd10);
        check("sw1_per1", burst_per[1], 64'd15);
        check("sw1_per2", burst_per[2], 64'd20);
        check("sw1_idx2", burst_idx[2], 64'd2);
        check("sw1_gap1", 64'(gap_len[1]), 64'd101);
        check("sw1_gap2", 64'(gap_len[2]), 64'd101);
        check("sw1_dones", 64'(dones), 64'd1);
        check("sw1_overrun", 64'(overrun), 64'd0);

        // step 0 from period 2: one 2048-cycle run; one dropped ready -> overrun
        kick(32'd2, 32'd0, 32'd100, 16'd1);
        observe(5000, 0, 100);
        check("st0_bursts", 64'(nb), 64'd1);
        check("st0_len", 64'(burst_len[0]), 64'd2048);
        check("st0_dones", 64'(dones), 64'd1);
        check("st0_overrun_sticky", 64'(overrun), 64'd1);

        // start above stop: config error, generator never enabled, overrun cleared
        kick(32'd30, 32'd1, 32'd20, 16'd1);
        observe(100, 0, 0);
        check("cfg_err_flag", 64'(cfg_err), 64'd1);
        check("cfg_overrun_clr", 64'(overrun), 64'd0);
        check("cfg_dones", 64'(dones), 64'd1);
        check("cfg_gen_seen", 64'(gen_seen), 64'd0);
        check("cfg_bursts", 64'(nb), 64'd0);

        // period 0 and osc_count 0 both behave as 1
        kick(32'd0, 32'd0, 32'd5, 16'd0);
        observe(3000, 0, 0);
        check("zero_len", 64'(burst_len[0]), 64'd1024);
        check("zero_per", burst_per[0], 64'd1);
        check("zero_cfg_err", 64'(cfg_err), 64'd0);

        // abort after 500 capture cycles of the first run
        kick(32'd10, 32'd5, 32'd20, 16'd1);
        observe(20000, 500, 0);
        check("abort_len", 64'(burst_len[0]), 64'd500);
        check("abort_dones", 64'(dones), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_gen_en", 64'(gen_en), 64'd0);
        check("abort_cv", 64'(capture_valid), 64'd0);
        check("abort_period_hold", 64'(period_out), 64'd10);

        // reset in the middle of a run
        kick(32'd10, 32'd5, 32'd20, 16'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_period_out", 64'(period_out), 64'd0);
        check("midrst_gen_en", 64'(gen_en), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_sweep_ctrl.md
FILTER_SWEEP_CTRL -- requirements
Module: filter_sweep_ctrl

Interface
REQ-001 Parameter PERIOD_W, 32, width of period and step values.
REQ-002 Parameter CNT_W, 40, width of the run-length and cycle counters.
REQ-003 Parameter GAP_CYCLES, 100, idle cycles between steps with the generator held off.
REQ-004 clk  in  1  single system clock (250 MHz).
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begins a sweep when sampled high in IDLE; ignored otherwise.
REQ-007 abort  in  1  terminates the sweep from any non-IDLE state.
REQ-008 period_start, period_step, period_stop  in  PERIOD_W each  sweep bounds; sampled only on accepted start.
REQ-009 osc_count  in  16  sine oscillations per step; sampled on accepted start.
REQ-010 settle_cycles  in  16  discard window per step; used only with FILTER_SWEEP_SETTLE_EN.
REQ-011 capture_ready  in  1  downstream logger can accept a sample.
REQ-012 period_out  out  PERIOD_W  period driven to sine_gen.
REQ-013 gen_en  out  1  high releases sine_gen and the filters; low holds them cleared.
REQ-014 capture_valid  out  1  current sine/filter bus sample is to be logged.
REQ-015 step_index  out  16  zero-based index of the current step.
REQ-016 busy, done, overrun, cfg_err  out  1 each  status flags.

Function
REQ-017 States: IDLE, LOAD, SETTLE, RUN, GAP, DONE.
REQ-018 IDLE + start -> LOAD; latch inputs; clear overrun, cfg_err, step_index.
REQ-019 cfg_err: if period_start > period_stop, set cfg_err, go LOAD -> DONE with gen_en never asserted.
REQ-020 A period of 0 is used as 1.
REQ-021 LOAD lasts one cycle: period_out = current period; run_len = period*1024*osc_count, saturated to all-ones on CNT_W overflow; osc_count 0 is used as 1.
REQ-022 gen_en is high in SETTLE and RUN only.
REQ-023 capture_valid is high in RUN only, for exactly run_len consecutive cycles.
REQ-024 RUN -> GAP after run_len cycles; GAP lasts GAP_CYCLES cycles with gen_en=0 and capture_valid=0.
REQ-025 Leaving GAP: next = period+period_step, computed one bit wider.
REQ-026 If period_step=0, next exceeds period_stop, or next overflows PERIOD_W -> DONE; otherwise period <= next, step_index++, -> LOAD.
REQ-027 DONE lasts one cycle, pulses done, then -> IDLE.
REQ-028 capture_valid high with capture_ready low sets overrun; overrun is sticky until the next accepted start; the sweep is not stalled.
REQ-029 abort has priority over all transitions: next cycle -> IDLE with gen_en=0, capture_valid=0, no done pulse; period_out holds its value.
REQ-030 busy is high in every state except IDLE.
REQ-031 start during busy is ignored; start and abort together in IDLE are ignored.

Reset
REQ-032 rst=1 on a clock edge forces IDLE, period_out=0, gen_en=0, capture_valid=0, step_index=0, busy=0, done=0, overrun=0, cfg_err=0, all counters=0.
REQ-033 rst mid-sweep behaves as REQ-032 with no done pulse; rst overrides start and abort.

Configuration
REQ-034 Macro FILTER_SWEEP_SETTLE_EN defined: LOAD -> SETTLE for settle_cycles cycles (gen_en=1, capture_valid=0) then RUN; settle_cycles=0 means SETTLE is skipped.
REQ-035 Macro undefined: LOAD -> RUN directly; settle_cycles is ignored; SETTLE is unreachable.

Verification
REQ-036 start, period 10/5/20, osc_count=1 -> three RUN bursts of 10240, 15360, 20480 capture_valid cycles; period_out 10, 15, 20; 100-cycle gaps; a single done pulse.
REQ-037 period_start=30, period_stop=20 -> cfg_err=1, done pulse, gen_en never high.
REQ-038 abort on cycle 500 of the first RUN -> IDLE next cycle, gen_en=0, no done, busy=0.
REQ-039 capture_ready low for 1 cycle during RUN -> overrun=1 held through DONE; cleared by the next start.
REQ-040 period_step=0, period_start=2 -> one RUN of 2048 cycles (osc_count=1), then done.
REQ-041 With FILTER_SWEEP_SETTLE_EN and settle_cycles=50 -> gen_en leads capture_valid by exactly 50 cycles per step.
